// File: rtl/prm_edge_scan.sv
// prm_edge_scan: sweeps 15-bit edge/configuration codes over [code_lo, code_hi],
// drives each code onto the combinational obstacle-check bank, ORs the returned
// per-obstacle masks into one collision bit per code, and streams the bits out
// packed into PACK_W-bit words over a valid/ready interface.
// Optional feature: define PRM_SCAN_HITCNT_EN to add the hit_cnt output, which
// counts the colliding codes of the current/last sweep.
module prm_edge_scan #(
    parameter int CODE_W  = 15,
    parameter int OBS_N   = 8,
    parameter int PACK_W  = 32,
    parameter int CHK_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CODE_W-1:0] code_lo,
    input  logic [CODE_W-1:0] code_hi,
    output logic [CODE_W-1:0] chk_code,
    input  logic [OBS_N-1:0]  chk_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PACK_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef PRM_SCAN_HITCNT_EN
    ,
    output logic [CODE_W:0]   hit_cnt
`endif
);

    localparam int FIFO_D = 4;
    localparam int CNT_W  = CODE_W + 1;
    localparam int PC_W   = $clog2(PACK_W + 1);
    localparam int IX_W   = $clog2(PACK_W);
    // The tag delay line keeps at least one bit so the vector is always legal.
    localparam int TL     = (CHK_LAT > 0) ? CHK_LAT : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FLUSH,
        FIN
    } state_t;

    // Sweep control state
    state_t            state_q, state_d;
    logic [CODE_W-1:0] cur_q, cur_d;
    logic [CODE_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [CODE_W-1:0] last_code_q, last_code_d;

    // Checker latency tags and result FIFO
    logic [TL-1:0]     tag_q, tag_d;
    logic [FIFO_D-1:0] fifo_q, fifo_d;
    logic [1:0]        wr_q, wr_d;
    logic [1:0]        rd_q, rd_d;
    logic [2:0]        fcnt_q, fcnt_d;

    // Packer state
    logic [PACK_W-1:0] pack_q, pack_d;
    logic [PC_W-1:0]   pack_cnt_q, pack_cnt_d;
    logic              pend_q, pend_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  popped_q, popped_d;

`ifdef PRM_SCAN_HITCNT_EN
    logic [CNT_W-1:0]  hit_q, hit_d;
`endif

    // Combinational handshakes between the processes
    logic              start_go;
    logic              issue;
    logic              emerge;
    logic              hit_bit;
    logic [2:0]        inflight;
    logic              credit;
    logic              xfer;
    logic              pop;
    logic              drain_ok;
    logic [IX_W-1:0]   idx;

    assign start_go  = (state_q == IDLE) && start;
    assign hit_bit   = |chk_mask;
    assign out_valid = pend_q || (state_q == FLUSH);
    assign out_last  = pend_q ? last_q : (state_q == FLUSH);
    assign out_data  = pack_q;
    assign xfer      = out_valid && out_ready;
    assign pop       = (fcnt_q != 3'd0) && (!pend_q || xfer);
    assign drain_ok  = (inflight == 3'd0) && (fcnt_q == 3'd0) && (!pend_q || xfer);
    // The bank sees the code being issued this cycle; otherwise the last one issued.
    assign chk_code  = issue ? cur_q : last_code_q;

    // Sweep FSM: range latch, code counter with credit-gated issue, drain and flush.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cur_d       = cur_q;
        hi_d        = hi_q;
        total_d     = total_q;
        last_code_d = last_code_q;
        issue       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    hi_d    = code_hi;
                    cur_d   = code_lo;
                    total_d = {1'b0, code_hi} - {1'b0, code_lo} + CNT_W'(1);
                    state_d = (code_hi < code_lo) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if (credit) begin
                    issue       = 1'b1;
                    last_code_d = cur_q;
                    // Stopping on equality keeps cur from ever wrapping at 0x7FFF.
                    if (cur_q == hi_q) begin
                        state_d = DRAIN;
                    end else begin
                        cur_d = cur_q + CODE_W'(1);
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_ok) begin
                    state_d = (pack_cnt_d != '0) ? FLUSH : FIN;
                end
            end
            FLUSH: begin
                busy = 1'b1;
                if (xfer) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Tag delay line, credit accounting and the 4-entry result FIFO.
    always_comb begin
        inflight = 3'd0;
        for (int i = 0; i < TL; i++) begin
            inflight = inflight + 3'(tag_q[i]);
        end
        // Tags in flight already own a FIFO slot, so the FIFO can never overflow.
        credit = ({1'b0, fcnt_q} + {1'b0, inflight}) < 4'(FIFO_D);

        if (CHK_LAT == 0) begin
            emerge = issue;
            tag_d  = '0;
        end else begin
            emerge = tag_q[TL-1];
            tag_d  = (tag_q << 1) | TL'(issue);
        end

        fifo_d = fifo_q;
        if (emerge) begin
            fifo_d[wr_q] = hit_bit;
        end
        wr_d   = wr_q + 2'(emerge);
        rd_d   = rd_q + 2'(pop);
        fcnt_d = fcnt_q + 3'(emerge) - 3'(pop);
    end

    // Packer: one FIFO pop per cycle into bit pack_cnt; a full word goes pending.
    always_comb begin
        pack_d     = pack_q;
        pack_cnt_d = pack_cnt_q;
        pend_d     = pend_q;
        last_d     = last_q;
        popped_d   = popped_q;
        idx        = '0;
        if (start_go) begin
            pack_d     = '0;
            pack_cnt_d = '0;
            pend_d     = 1'b0;
            last_d     = 1'b0;
            popped_d   = '0;
        end
        if (xfer) begin
            pack_d     = '0;
            pack_cnt_d = '0;
            pend_d     = 1'b0;
            last_d     = 1'b0;
        end
        // Popping after the transfer update lets the next word start in the same cycle.
        if (pop) begin
            idx         = pack_cnt_d[IX_W-1:0];
            pack_d[idx] = fifo_q[rd_q];
            pack_cnt_d  = pack_cnt_d + PC_W'(1);
            popped_d    = popped_q + CNT_W'(1);
            if (popped_q == total_q - CNT_W'(1)) begin
                last_d = 1'b1;
            end
            if (pack_cnt_d == PC_W'(PACK_W)) begin
                pend_d = 1'b1;
            end
        end
    end

`ifdef PRM_SCAN_HITCNT_EN
    // Saturating count of colliding codes, restarted by each accepted start.
    always_comb begin
        hit_d = hit_q;
        if (start_go) begin
            hit_d = '0;
        end else if (emerge && hit_bit && !(&hit_q)) begin
            hit_d = hit_q + CNT_W'(1);
        end
    end

    assign hit_cnt = hit_q;
`endif

    // State registers; asynchronous reset abandons any sweep in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            hi_q        <= '0;
            total_q     <= '0;
            last_code_q <= '0;
            tag_q       <= '0;
            // NOTE: the FIFO storage is reset too, so a sweep cut short by reset
            // can never leave stale collision bits visible to the next one.
            fifo_q      <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            fcnt_q      <= '0;
            pack_q      <= '0;
            pack_cnt_q  <= '0;
            pend_q      <= 1'b0;
            last_q      <= 1'b0;
            popped_q    <= '0;
`ifdef PRM_SCAN_HITCNT_EN
            hit_q       <= '0;
`endif
        end else begin
            // NOTE: non-blocking here so every flop samples the pre-edge _d
            // values; the always_comb blocks above use blocking assignments.
            state_q     <= state_d;
            cur_q       <= cur_d;
            hi_q        <= hi_d;
            total_q     <= total_d;
            last_code_q <= last_code_d;
            tag_q       <= tag_d;
            fifo_q      <= fifo_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            fcnt_q      <= fcnt_d;
            pack_q      <= pack_d;
            pack_cnt_q  <= pack_cnt_d;
            pend_q      <= pend_d;
            last_q      <= last_d;
            popped_q    <= popped_d;
`ifdef PRM_SCAN_HITCNT_EN
            hit_q       <= hit_d;
`endif
        end
    end

endmodule

// File: tb/tb_prm_edge_scan.sv
// Self-checking bench for prm_edge_scan: the bench plays the obstacle-check
// bank (one register stage of latency) and compares every streamed word with a
// reference model computed directly from the code range and the bank's masks.
module tb_prm_edge_scan;

    logic        clk;
    logic        rst;
    logic        start;
    logic [14:0] code_lo;
    logic [14:0] code_hi;
    logic [14:0] chk_code;
    logic [7:0]  chk_mask;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef PRM_SCAN_HITCNT_EN
    logic [15:0] hit_cnt;
`endif

    prm_edge_scan dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .code_lo  (code_lo),
        .code_hi  (code_hi),
        .chk_code (chk_code),
        .chk_mask (chk_mask),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
`ifdef PRM_SCAN_HITCNT_EN
        ,
        .hit_cnt  (hit_cnt)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    typedef struct {
        logic [14:0] lo;
        logic [14:0] hi;
        int          mode;
        int          rdy;
        int          exp_nw;
        bit          chk_w0;
        logic [31:0] w0;
        int          max_lat;
    } vec_t;

    word_t         got_q[$];
    word_t         exp_q[$];
    logic [14:0]   seen_q[$];
    vec_t          vecs[9];

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc;
    int            done_total;
    int            done_cyc;
    int            done_base;
    int            start_cyc;
    int            exp_hits;
    int            cur_mode;
    int unsigned   cur_seed;
    int            rdy_p;
    logic [14:0]   cur_lo;
    logic [14:0]   cur_hi;
    bit            prev_stall;
    logic [31:0]   prev_data;
    logic          prev_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Checker bank stand-in: mode 0 flags odd codes, mode 1 flags everything,
    // mode 2 is a seeded pseudo-random obstacle pattern.
    function automatic logic [7:0] mask_of(input logic [14:0] code, input int mode,
                                           input int unsigned seed);
        int unsigned h;
        h = ({17'd0, code} * 32'h9E3779B1) ^ seed;
        h = h ^ (h >> 15);
        case (mode)
            0:       return code[0] ? 8'h01 : 8'h00;
            1:       return 8'hFF;
            default: return h[20] ? (8'h01 << h[2:0]) : 8'h00;
        endcase
    endfunction

    // Bank output appears one cycle after the code it answers.
    always @(posedge clk) chk_mask <= mask_of(chk_code, cur_mode, cur_seed);

    function automatic logic rnd_ready();
        if (rdy_p >= 100) return 1'b1;
        return int'($urandom_range(0, 99)) < rdy_p;
    endfunction

    // Output monitor: collects transfers, codes driven while busy, done pulses,
    // and checks that a stalled word holds steady.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) got_q.push_back(word_t'{out_data, out_last});
            if (busy) seen_q.push_back(chk_code);
            if (done) begin
                done_total <= done_total + 1;
                done_cyc   <= cyc;
            end
        end
        prev_stall <= !rst && out_valid && !out_ready;
        prev_data  <= out_data;
        prev_last  <= out_last;
    end

    // Reference model: code k of the sweep lands in word k/32, bit k%32.
    task automatic build_model(input logic [14:0] lo, input logic [14:0] hi,
                               input int mode, input int unsigned seed);
        int    n;
        bit    c;
        word_t w;
        exp_q.delete();
        exp_hits = 0;
        w.data = '0;
        w.last = 1'b0;
        if (hi >= lo) begin
            n = int'(hi) - int'(lo) + 1;
            for (int k = 0; k < n; k++) begin
                c = (mask_of(15'(int'(lo) + k), mode, seed) != 8'h00);
                if (c) exp_hits++;
                w.data[k % 32] = c;
                if ((k % 32 == 31) || (k == n - 1)) begin
                    w.last = (k == n - 1);
                    exp_q.push_back(w);
                    w.data = '0;
                end
            end
        end
    endtask

    task automatic run_sweep(input logic [14:0] lo, input logic [14:0] hi,
                             input int mode, input int rdy);
        int n;
        int budget;
        int waited;
        cur_mode = mode;
        cur_seed = $urandom;
        rdy_p    = rdy;
        cur_lo   = lo;
        cur_hi   = hi;
        n        = (hi >= lo) ? (int'(hi) - int'(lo) + 1) : 0;
        budget   = 40 * n + 100;
        got_q.delete();
        seen_q.delete();
        done_base = done_total;
        @(posedge clk);
        #1;
        code_lo   = lo;
        code_hi   = hi;
        start     = 1'b1;
        out_ready = rnd_ready();
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start  = 1'b0;
        waited = 0;
        while (done_total == done_base && waited < budget) begin
            out_ready = rnd_ready();
            @(posedge clk);
            #1;
            waited++;
        end
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_sweep(input string tag, input int exp_nw, input bit chk_w0,
                               input logic [31:0] w0, input int max_lat);
        int n;
        int cov;
        int bad;
        int lim;
        bit hitmap[256];
        build_model(cur_lo, cur_hi, cur_mode, cur_seed);
        check({tag, "_done_cnt"}, done_total - done_base, 1);
        check({tag, "_nwords"}, got_q.size(), exp_nw);
        check({tag, "_nwords_model"}, got_q.size(), exp_q.size());
        lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) begin
            check($sformatf("%s_w%0d_data", tag, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s_w%0d_last", tag, i), got_q[i].last, exp_q[i].last);
        end
        if (chk_w0 && got_q.size() > 0) check({tag, "_w0_const"}, got_q[0].data, w0);
        if (cur_hi < cur_lo) begin
            check({tag, "_done_lat"}, done_cyc - start_cyc, 1);
            check({tag, "_no_busy"}, seen_q.size(), 0);
        end else begin
            if (max_lat > 0) check({tag, "_lat_ok"}, (done_cyc - start_cyc) <= max_lat, 1);
            n   = int'(cur_hi) - int'(cur_lo) + 1;
            cov = 0;
            bad = 0;
            foreach (seen_q[i]) begin
                if (seen_q[i] >= cur_lo && seen_q[i] <= cur_hi) begin
                    hitmap[int'(seen_q[i]) - int'(cur_lo)] = 1'b1;
                end else begin
                    bad++;
                end
            end
            for (int k = 0; k < n; k++) cov += int'(hitmap[k]);
            check({tag, "_codes_seen"}, cov, n);
            check({tag, "_codes_oob"}, bad, 0);
        end
`ifdef PRM_SCAN_HITCNT_EN
        check({tag, "_hit_cnt"}, hit_cnt, exp_hits);
`endif
    endtask

    // Reset lands while code 40 of 0..127 is on the bank; then a clean sweep.
    task automatic reset_mid_sweep();
        int waited;
        cur_mode = 0;
        rdy_p    = 100;
        @(posedge clk);
        #1;
        code_lo   = 15'd0;
        code_hi   = 15'd127;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        waited = 0;
        while (chk_code != 15'd40 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("rst_reach40", chk_code, 40);
        #2;
        rst = 1'b1;
        #1;
        check("rst_chk_code", chk_code, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        repeat (5) @(posedge clk);
        #1;
        check("rst_no_partial_word", got_q.size(), 0);
        check("rst_idle_busy", busy, 0);
        run_sweep(15'd0, 15'd31, 0, 100);
        check_sweep("rst_again", 1, 1'b1, 32'hAAAAAAAA, 37);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        code_lo   = '0;
        code_hi   = '0;
        out_ready = 1'b0;
        cur_mode  = 0;
        cur_seed  = 0;
        rdy_p     = 100;
        cur_lo    = '0;
        cur_hi    = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_last", out_last, 0);
        check("reset_out_data", out_data, 0);
        check("reset_chk_code", chk_code, 0);
`ifdef PRM_SCAN_HITCNT_EN
        check("reset_hit_cnt", hit_cnt, 0);
`endif
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        //          lo        hi        mode rdy  nw chk_w0 w0            max_lat
        vecs[0] = '{15'd0,    15'd31,   0,   100, 1, 1'b1, 32'hAAAAAAAA, 37};
        vecs[1] = '{15'd5,    15'd9,    1,   100, 1, 1'b1, 32'h0000001F, 0};
        vecs[2] = '{15'd0,    15'd95,   2,   30,  3, 1'b0, 32'h0,        0};
        vecs[3] = '{15'h7FE0, 15'h7FFF, 0,   100, 1, 1'b1, 32'hAAAAAAAA, 37};
        vecs[4] = '{15'd10,   15'd3,    0,   100, 0, 1'b0, 32'h0,        0};
        vecs[5] = '{15'd0,    15'd32,   1,   50,  2, 1'b0, 32'h0,        0};
        vecs[6] = '{15'd7,    15'd7,    0,   100, 1, 1'b1, 32'h00000001, 0};
        vecs[7] = '{15'd100,  15'd163,  2,   100, 2, 1'b0, 32'h0,        0};
        vecs[8] = '{15'h7FFF, 15'h7FFF, 0,   100, 1, 1'b1, 32'h00000001, 0};

        for (int i = 0; i < 9; i++) begin
            run_sweep(vecs[i].lo, vecs[i].hi, vecs[i].mode, vecs[i].rdy);
            check_sweep($sformatf("vec%0d", i), vecs[i].exp_nw, vecs[i].chk_w0,
                        vecs[i].w0, vecs[i].max_lat);
        end

        for (int r = 0; r < 6; r++) begin
            int lo_i;
            int len;
            int rp;
            lo_i = int'($urandom_range(0, 32767 - 160));
            len  = int'($urandom_range(1, 150));
            rp   = (r % 3 == 0) ? 30 : ((r % 3 == 1) ? 60 : 100);
            run_sweep(15'(lo_i), 15'(lo_i + len - 1), 2, rp);
            check_sweep($sformatf("rnd%0d", r), (len + 31) / 32, 1'b0, 32'h0, 0);
        end

        reset_mid_sweep();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
